// File: rtl/sha_pad.sv
// sha_pad: SHA-256 message padder. It streams message words, then 0x80, zero fill and
// the 64-bit bit length to a SHA core in 16-word blocks. Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module sha_pad (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_vld,
  input  logic [31:0] s_din,
  input  logic        s_last,
  input  logic [1:0]  s_bytes,
  output logic        s_rdy,
  output logic        init,
  output logic        vld,
  output logic [31:0] din,
  input  logic        done,
  output logic        busy,
  output logic        msg_done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INIT      = 3'd1,
    DATA      = 3'd2,
    PAD80     = 3'd3,
    ZERO      = 3'd4,
    LEN_HI    = 3'd5,
    LEN_LO    = 3'd6,
    WAIT_DONE = 3'd7
  } state_t;

  state_t      r_state, r_resume;
  logic [3:0]  r_wcnt;
  logic [31:0] r_bytes;
  logic        r_vld;
  logic [31:0] r_din;
  logic        r_final;

  state_t      w_state_nxt, w_resume_nxt, w_pad_nxt;
  logic [3:0]  w_wcnt_nxt;
  logic [31:0] w_bytes_nxt;
  logic        w_vld_nxt;
  logic [31:0] w_din_nxt;
  logic        w_final_nxt;
  logic        w_accept;
  logic        w_wrap;
  logic [31:0] w_nb;
  logic [31:0] w_last_word;

  assign w_accept = s_vld & (r_state == DATA);
  assign w_wrap   = (r_wcnt == 4'd15);
  assign w_nb     = (s_bytes == 2'd0) ? 32'd4 : {30'd0, s_bytes};

  // Next state after emitting a padding word: block full, length next, or more zeros.
  assign w_pad_nxt = w_wrap ? WAIT_DONE : ((r_wcnt == 4'd13) ? LEN_HI : ZERO);

  always_comb begin
    w_last_word = s_din;
    case (s_bytes)
      2'd1:    w_last_word = {s_din[31:24], 8'h80, 16'h0000};
      2'd2:    w_last_word = {s_din[31:16], 8'h80, 8'h00};
      2'd3:    w_last_word = {s_din[31:8], 8'h80};
      default: w_last_word = s_din;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_resume_nxt = r_resume;
    w_wcnt_nxt   = r_wcnt;
    w_bytes_nxt  = r_bytes;
    w_vld_nxt    = 1'b0;
    w_din_nxt    = r_din;
    w_final_nxt  = r_final;
    case (r_state)
      IDLE: begin
        if (s_vld) w_state_nxt = INIT;
      end
      INIT: begin
        w_wcnt_nxt  = 4'd0;
        w_bytes_nxt = 32'd0;
        w_final_nxt = 1'b0;
        w_state_nxt = DATA;
      end
      DATA: begin
        if (w_accept) begin
          w_vld_nxt  = 1'b1;
          w_wcnt_nxt = r_wcnt + 4'd1;
          if (s_last) begin
            w_din_nxt   = w_last_word;
            w_bytes_nxt = r_bytes + w_nb;
            if (s_bytes == 2'd0) begin
              w_state_nxt  = w_wrap ? WAIT_DONE : PAD80;
              w_resume_nxt = PAD80;
            end else begin
              w_state_nxt  = w_pad_nxt;
              w_resume_nxt = ZERO;
            end
          end else begin
            w_din_nxt    = s_din;
            w_bytes_nxt  = r_bytes + 32'd4;
            w_state_nxt  = w_wrap ? WAIT_DONE : DATA;
            w_resume_nxt = DATA;
          end
        end
      end
      PAD80: begin
        w_vld_nxt    = 1'b1;
        w_din_nxt    = 32'h8000_0000;
        w_wcnt_nxt   = r_wcnt + 4'd1;
        w_state_nxt  = w_pad_nxt;
        w_resume_nxt = ZERO;
      end
      ZERO: begin
        w_vld_nxt    = 1'b1;
        w_din_nxt    = 32'h0000_0000;
        w_wcnt_nxt   = r_wcnt + 4'd1;
        w_state_nxt  = w_pad_nxt;
        w_resume_nxt = ZERO;
      end
      LEN_HI: begin
        w_vld_nxt   = 1'b1;
        w_din_nxt   = {29'd0, r_bytes[31:29]};
        w_wcnt_nxt  = r_wcnt + 4'd1;
        w_state_nxt = LEN_LO;
      end
      LEN_LO: begin
        w_vld_nxt   = 1'b1;
        w_din_nxt   = {r_bytes[28:0], 3'b000};
        w_wcnt_nxt  = r_wcnt + 4'd1;
        w_final_nxt = 1'b1;
        w_state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done) w_state_nxt = r_final ? IDLE : r_resume;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_resume <= DATA;
      r_wcnt   <= 4'd0;
      r_bytes  <= 32'd0;
      r_vld    <= 1'b0;
      r_din    <= 32'd0;
      r_final  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_resume <= w_resume_nxt;
      r_wcnt   <= w_wcnt_nxt;
      r_bytes  <= w_bytes_nxt;
      r_vld    <= w_vld_nxt;
      r_din    <= w_din_nxt;
      r_final  <= w_final_nxt;
    end
  end

  assign s_rdy    = (r_state == DATA);
  assign init     = (r_state == INIT);
  assign busy     = (r_state != IDLE);
  assign msg_done = (r_state == WAIT_DONE) & r_final & done;
  assign vld      = r_vld;
  assign din      = r_din;

endmodule

`default_nettype wire

// File: tb/tb_sha_pad.sv
// tb_sha_pad: directed messages against a byte-level padding model of sha_pad.
`timescale 1ns/1ps
`default_nettype none

module tb_sha_pad;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_vld;
  logic [31:0] s_din;
  logic        s_last;
  logic [1:0]  s_bytes;
  logic        s_rdy;
  logic        init;
  logic        vld;
  logic [31:0] din;
  logic        done;
  logic        busy;
  logic        msg_done;
  logic        drv_done;
  logic        spur_done;

  int checks = 0;
  int errors = 0;
  int md_cnt = 0;
  int init_cnt = 0;
  int blk_words = 0;

  logic [7:0]  msg_b[$];
  logic [31:0] mq[$];
  logic [31:0] exp_q[$];

  assign done = drv_done | spur_done;

  sha_pad dut (
    .clk(clk), .rst_n(rst_n), .s_vld(s_vld), .s_din(s_din), .s_last(s_last),
    .s_bytes(s_bytes), .s_rdy(s_rdy), .init(init), .vld(vld), .din(din),
    .done(done), .busy(busy), .msg_done(msg_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Padding from first principles: bytes, 0x80, zeros to 56 mod 64, 64-bit bit length.
  task automatic build_model();
    logic [7:0]  p[$];
    logic [63:0] bl;
    mq.delete();
    p  = msg_b;
    bl = 64'(msg_b.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
    for (int k = 0; k < p.size(); k += 4) mq.push_back({p[k], p[k+1], p[k+2], p[k+3]});
  endtask

  task automatic make_msg(input int n);
    msg_b.delete();
    for (int k = 0; k < n; k++) msg_b.push_back(8'(k + 1));
  endtask

  // Core stand-in: pulse done a few cycles after every 16th word.
  initial begin
    int bc;
    bc = 0;
    drv_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) bc = 0;
      else if (vld) begin
        bc++;
        if (bc == 16) begin
          bc = 0;
          repeat (3) @(posedge clk);
          #1 drv_done = 1'b1;
          @(posedge clk);
          #1 drv_done = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic exp_md;
    logic [31:0] w;
    if (!rst_n) begin
      blk_words = 0;
    end else begin
      if (init && vld) chk("init_vld_overlap", 32'd1, 32'd0);
      exp_md = done && (blk_words == 16) && (exp_q.size() == 0);
      chk("msg_done", {31'd0, msg_done}, {31'd0, exp_md});
      if (msg_done) md_cnt++;
      if (init) init_cnt++;
      if (vld) begin
        if (exp_q.size() == 0) chk("unexpected_word", din, 32'hxxxx_xxxx);
        else begin
          w = exp_q.pop_front();
          chk("din", din, w);
        end
        blk_words++;
        if (blk_words > 16) chk("block_len", blk_words, 32'd16);
      end
      if (blk_words == 16) chk("s_rdy_wait", {31'd0, s_rdy}, 32'd0);
      if (done && blk_words == 16) blk_words = 0;
    end
  end

  task automatic send_msg(input bit gap, input bit spur);
    int n, nw, t;
    n  = msg_b.size();
    nw = (n + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      for (int b = 0; b < 4; b++)
        s_din[31-8*b -: 8] = (4*k + b < n) ? msg_b[4*k + b] : 8'hA5;
      s_last  = (k == nw - 1);
      s_bytes = (k == nw - 1) ? 2'(n % 4) : 2'd0;
      s_vld   = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!s_rdy && t < 3000);
      if (!s_rdy) begin
        chk("accept_timeout", 32'd0, 32'd1);
        s_vld = 1'b0;
        return;
      end
      @(posedge clk);
      #1 s_vld = 1'b0;
      s_last = 1'b0;
      if (gap) begin
        @(posedge clk);
        #1;
      end
      if (spur && k == 5) begin
        spur_done = 1'b1;
        @(posedge clk);
        #1 spur_done = 1'b0;
      end
    end
  endtask

  task automatic run_msg(input bit gap, input bit spur);
    int md0, i0, t;
    md0 = md_cnt;
    i0  = init_cnt;
    foreach (mq[k]) exp_q.push_back(mq[k]);
    send_msg(gap, spur);
    t = 0;
    while (md_cnt == md0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("msg_done_seen", md_cnt - md0, 32'd1);
    @(negedge clk);
    chk("words_left", exp_q.size(), 32'd0);
    chk("init_count", init_cnt - i0, 32'd1);
    chk("busy_after", {31'd0, busy}, 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int t;
    rst_n = 1'b0; s_vld = 1'b0; s_din = 32'd0; s_last = 1'b0; s_bytes = 2'd0;
    spur_done = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_outs", {26'd0, s_rdy, init, vld, busy, msg_done, 1'b0}, 32'd0);
    chk("rst_din", din, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", {30'd0, busy, s_rdy}, 32'd0);

    msg_b = '{8'h61, 8'h62, 8'h63};
    build_model();
    chk("model_abc_w0", mq[0], 32'h6162_6380);
    chk("model_abc_w15", mq[15], 32'h0000_0018);
    chk("model_abc_len", mq.size(), 32'd16);
    run_msg(1'b0, 1'b0);

    make_msg(55);
    build_model();
    chk("model_55_w13", mq[13], 32'h3536_3780);
    chk("model_55_w15", mq[15], 32'h0000_01B8);
    run_msg(1'b0, 1'b1);

    make_msg(56);
    build_model();
    chk("model_56_len", mq.size(), 32'd32);
    chk("model_56_w14", mq[14], 32'h8000_0000);
    chk("model_56_w31", mq[31], 32'h0000_01C0);
    run_msg(1'b0, 1'b0);

    make_msg(64);
    build_model();
    chk("model_64_w16", mq[16], 32'h8000_0000);
    chk("model_64_w31", mq[31], 32'h0000_0200);
    run_msg(1'b1, 1'b0);

    make_msg(6);
    build_model();
    chk("model_6_w1", mq[1], 32'h0506_8000);
    chk("model_6_w15", mq[15], 32'h0000_0030);
    run_msg(1'b0, 1'b0);

    // Abandon a message partway through its second-block padding.
    make_msg(56);
    build_model();
    foreach (mq[k]) exp_q.push_back(mq[k]);
    send_msg(1'b0, 1'b0);
    t = 0;
    while (exp_q.size() > 12 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("reach_block2", {31'd0, exp_q.size() <= 12}, 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {27'd0, s_rdy, init, vld, busy, msg_done}, 32'd0);
    chk("async_rst_din", din, 32'd0);
    repeat (2) @(posedge clk);
    exp_q.delete();
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {31'd0, busy}, 32'd0);

    msg_b = '{8'h61, 8'h62, 8'h63};
    build_model();
    run_msg(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
